// File: rtl/alu_pkg.sv
// Shared definitions for the execute sequencer: op codes, instruction layout, FSM states.
// No logic. Latency: n/a. Backpressure: n/a.
// Field positions document the packed layout of instr_t for code that slices raw words.
package alu_pkg;

   localparam logic [2:0] OP_PASS2   = 3'd0;
   localparam logic [2:0] OP_PASS1   = 3'd1;
   localparam logic [2:0] OP_ADD     = 3'd2;
   localparam logic [2:0] OP_MUL     = 3'd3;
   localparam logic [2:0] OP_EQ      = 3'd4;
   localparam logic [2:0] OP_LT      = 3'd5;
   localparam logic [2:0] OP_NOT2    = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   localparam int OP_LSB  = 13;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 5;
   localparam int RS2_LSB = 1;
   localparam int WB_BIT  = 0;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic       wb_en;
   } instr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   function automatic logic is_illegal(input logic [2:0] op);
      return op == OP_ILLEGAL;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two async read ports and one sync write port; entry 0 reads as zero.
// Latency: reads combinational, writes visible the cycle after the write edge.
// Backpressure: none, a write is taken whenever we is high.
module regfile_2r1w #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr1,
   output logic [DW-1:0] rdata1,
   input  logic [AW-1:0] raddr2,
   output logic [DW-1:0] rdata2
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/alu_exec_seq.sv
// Execute sequencer: reads two registers, drives an external ALU, writes the result back.
// Latency: accept edge T -> done in the cycle after edge T+2, writeback at edge T+3.
// Backpressure: in_ready only in IDLE with no host load pending; one instruction per 4 cycles.
module alu_exec_seq
   import alu_pkg::*;
#(
   parameter int REG_AW  = 4,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   input  logic               ld_we,
   input  logic [REG_AW-1:0]  ld_addr,
   input  logic [31:0]        ld_data,
   output logic [2:0]         alu_op,
   output logic [31:0]        alu_in1,
   output logic [31:0]        alu_in2,
   input  logic [31:0]        alu_out,
   output logic               done,
   output logic [31:0]        result,
   output logic               err
);

   state_t      state_q, state_d;
   instr_t      in_f, instr_q;
   logic        accept;
   logic        rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] rdata1, rdata2;

   assign in_f     = instr_t'(in_instr);
   assign in_ready = (state_q == IDLE) & ~ld_we;
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && !is_illegal(in_f.op)) state_d = READ;
         READ:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= '0;
         alu_op  <= '0;
         alu_in1 <= '0;
         alu_in2 <= '0;
         result  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         // Illegal ops are consumed by the handshake but never leave IDLE.
         err  <= accept & is_illegal(in_f.op);
         done <= (state_q == EXEC);
         if (accept && !is_illegal(in_f.op)) instr_q <= in_f;
         if (state_q == READ) begin
            alu_op  <= instr_q.op;
            alu_in1 <= rdata1;
            alu_in2 <= rdata2;
         end
         if (state_q == EXEC) result <= alu_out;
      end
   end

   // Host loads only land in IDLE; writeback owns the port in WB.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = ld_addr;
      rf_wdata = ld_data;
      if (state_q == IDLE) begin
         rf_we = ld_we;
      end else if (state_q == WB) begin
         rf_we    = instr_q.wb_en & (instr_q.rd != '0);
         rf_waddr = REG_AW'(instr_q.rd);
         rf_wdata = result;
      end
   end

   regfile_2r1w #(
      .AW (REG_AW),
      .DW (32)
   ) u_rf (
      .clk    (clk),
      .rst    (rst),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .raddr1 (REG_AW'(instr_q.rs1)),
      .rdata1 (rdata1),
      .raddr2 (REG_AW'(instr_q.rs2)),
      .rdata2 (rdata2)
   );

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench: issued instructions push expected done/err events; a monitor pops and compares.
// The bench supplies the combinational ALU the sequencer drives.
module tb_alu_exec_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        ld_we;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;
   logic [2:0]  alu_op;
   logic [31:0] alu_in1, alu_in2, alu_out;
   logic        done, err;
   logic [31:0] result;

   typedef struct {
      bit          is_err;
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_exec_seq #(.REG_AW(4), .INSTR_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_instr (in_instr),
      .in_ready (in_ready),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .alu_op   (alu_op),
      .alu_in1  (alu_in1),
      .alu_in2  (alu_in2),
      .alu_out  (alu_out),
      .done     (done),
      .result   (result),
      .err      (err)
   );

   logic signed [15:0] m_a, m_b;
   logic signed [31:0] m_p;
   always_comb begin
      m_a = alu_in1[15:0];
      m_b = alu_in2[15:0];
      m_p = m_a * m_b;
      case (alu_op)
         3'd0:    alu_out = alu_in2;
         3'd1:    alu_out = alu_in1;
         3'd2:    alu_out = alu_in1 + alu_in2;
         3'd3:    alu_out = m_p;
         3'd4:    alu_out = {31'd0, alu_in1 == alu_in2};
         3'd5:    alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
         3'd6:    alu_out = ~alu_in2;
         default: alu_out = 32'd0;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2, input bit wb);
      return {op[2:0], rd[3:0], rs1[3:0], rs2[3:0], wb};
   endfunction

   // Monitor: every done/err pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (done && err) chk("done_err_exclusive", 32'd1, 32'd0);
         if (done || err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, err, done}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pulse_kind_err", {31'd0, err}, {31'd0, e.is_err});
               chk("pulse_cycle", cyc, e.cyc);
               if (!e.is_err) chk("result", result, e.res);
            end
         end
      end
   end

   task automatic load(input int addr, input logic [31:0] data);
      @(negedge clk);
      ld_we = 1'b1; ld_addr = addr[3:0]; ld_data = data;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   // Accepted at edge T: err seen at cycle T, done two edges later.
   task automatic issue(input logic [15:0] ins, input bit is_err, input logic [31:0] res,
                        input bit push, output int acc);
      int b;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1; in_instr = ins;
      b = 0;
      while (!in_ready && b < 50) begin
         @(negedge clk);
         b++;
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      acc = cyc + 1;
      if (push) begin
         e.is_err = is_err; e.res = res; e.cyc = is_err ? acc : acc + 2;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int b;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while ((exp_q.size() != 0 || !in_ready) && b < 100);
      if (b >= 100) chk("drain_timeout", exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_alu_op"},  {29'd0, alu_op}, 32'd0);
      chk({tag, "_alu_in1"}, alu_in1, 32'd0);
      chk({tag, "_alu_in2"}, alu_in2, 32'd0);
      chk({tag, "_result"},  result, 32'd0);
      chk({tag, "_done"},    {31'd0, done}, 32'd0);
      chk({tag, "_err"},     {31'd0, err}, 32'd0);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int a1, a2, a3, t;
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // add with wrap: 5 + (-3) = 2 into R3, then read R3 back
      load(1, 32'd5);
      load(2, 32'hFFFF_FFFD);
      issue(mk(2, 3, 1, 2, 1), 0, 32'd2, 1, t);
      drain();
      issue(mk(1, 0, 3, 0, 0), 0, 32'd2, 1, t);
      drain();

      // multiply ignores upper halves; compare ops yield 0/1
      load(1, 32'h0001_0002);
      load(2, 32'd3);
      issue(mk(3, 0, 1, 2, 0), 0, 32'd6, 1, t);
      issue(mk(4, 0, 1, 1, 0), 0, 32'd1, 1, t);
      issue(mk(5, 0, 2, 1, 0), 0, 32'd1, 1, t);
      issue(mk(5, 0, 1, 2, 0), 0, 32'd0, 1, t);
      drain();

      // illegal op: err pulse only, ready stays high, R3 untouched
      issue(mk(7, 3, 1, 2, 1), 1, 32'd0, 1, t);
      @(negedge clk);
      chk("ready_after_illegal", {31'd0, in_ready}, 32'd1);
      drain();
      issue(mk(1, 0, 3, 0, 0), 0, 32'd2, 1, t);
      drain();

      // rd=0 writeback discarded; wb_en=0 leaves rd unchanged
      issue(mk(6, 0, 0, 0, 1), 0, 32'hFFFF_FFFF, 1, t);
      issue(mk(1, 0, 0, 0, 0), 0, 32'd0, 1, t);
      issue(mk(0, 3, 0, 1, 0), 0, 32'h0001_0002, 1, t);
      issue(mk(1, 0, 3, 0, 0), 0, 32'd2, 1, t);
      drain();

      // back-to-back instructions are accepted every 4 cycles
      issue(mk(1, 0, 1, 0, 0), 0, 32'h0001_0002, 1, a1);
      issue(mk(0, 0, 0, 2, 0), 0, 32'd3, 1, a2);
      issue(mk(2, 0, 1, 2, 0), 0, 32'h0001_0005, 1, a3);
      chk("accept_gap_1", a2 - a1, 32'd4);
      chk("accept_gap_2", a3 - a2, 32'd4);
      drain();

      // host load beats instruction acceptance in the same cycle
      @(negedge clk);
      ld_we = 1'b1; ld_addr = 4'd4; ld_data = 32'd7;
      in_valid = 1'b1; in_instr = mk(1, 0, 4, 0, 0);
      #1 chk("ready_low_during_load", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      ld_we = 1'b0;
      #1 chk("ready_after_load", {31'd0, in_ready}, 32'd1);
      begin
         exp_t e;
         e.is_err = 0; e.res = 32'd7; e.cyc = cyc + 3;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();

      // reset during EXEC abandons the instruction
      issue(mk(2, 5, 1, 2, 1), 0, 32'd0, 0, t);
      @(negedge clk);
      @(negedge clk);
      chk("in_exec_alu_in1", alu_in1, 32'h0001_0002);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      issue(mk(1, 0, 5, 0, 0), 0, 32'd0, 1, t);
      issue(mk(1, 0, 1, 0, 0), 0, 32'd0, 1, t);
      drain();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Multi-cycle execute sequencer that sits directly upstream of the combinational 3-bit-op ALU and also consumes its output.
- Accepts one 16-bit instruction per valid/ready handshake and reads two operands from an internal register file.
- Drives the ALU's op/in1/in2 from registers, captures the ALU result and writes it back to the destination register.
- Provides a host load port for initialising registers, plus done/err status pulses.

Parameters:
- REG_AW, 4, register address width; the register file holds 2**REG_AW entries of 32 bits.
- INSTR_W, 16, instruction width. Fixed at 16; any other value is unsupported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  instruction valid.
- in_instr  in  16  fields: [15:13] op, [12:9] rd, [8:5] rs1, [4:1] rs2, [0] wb_en.
- in_ready  out  1  high = instruction is accepted this cycle if in_valid is high.
- ld_we  in  1  host register write strobe.
- ld_addr  in  REG_AW  host write address.
- ld_data  in  32  host write data.
- alu_op  out  3  op to the ALU (registered).
- alu_in1  out  32  operand 1 to the ALU (registered).
- alu_in2  out  32  operand 2 to the ALU (registered).
- alu_out  in  32  ALU result, combinational from alu_op/alu_in1/alu_in2.
- done  out  1  one-cycle pulse when an instruction retires.
- result  out  32  retired result; holds its value until the next retire.
- err  out  1  one-cycle pulse when an illegal op is discarded.

Behaviour:
- FSM states: IDLE, READ, EXEC, WB.
- Reset (synchronous, takes priority over everything):
  - state=IDLE; all register-file entries=0.
  - alu_op=0, alu_in1=0, alu_in2=0, result=0, done=0, err=0.
  - The latched instruction is cleared.
  - Reset asserted mid-operation abandons the instruction: no writeback, no done pulse.
- in_ready = (state==IDLE) & ~ld_we. A host load wins over instruction acceptance in the same cycle.
- ld_we has effect only in IDLE; it is ignored in all other states. Writes to address 0 are ignored.
- Register 0 always reads as 0.
- IDLE:
  - On in_valid&in_ready, latch in_instr and go to READ.
  - If op==7 (illegal): pulse err next cycle, stay in IDLE, no state change otherwise, in_ready stays high.
- READ:
  - alu_op<=op; alu_in1<=R[rs1]; alu_in2<=R[rs2].
  - Go to EXEC.
- EXEC:
  - ALU inputs are stable; result<=alu_out at the end of the cycle.
  - Go to WB.
- WB:
  - done=1 for this cycle only.
  - If wb_en and rd!=0, then R[rd]<=result at the end of the cycle.
  - Go to IDLE.
- Latency: instruction accepted at edge T; done is high during cycle T+3; the write is visible to a read in READ at T+5 at the earliest.
- Throughput: one instruction per 4 cycles. No overlap, so no hazards or forwarding.
- ALU outputs hold their values outside READ→EXEC.
- Ops 4 (equality) and 5 (less-than) return 0 or 1 in result[0] with bits [31:1]=0. This is a check on the ALU, not logic in this block.
- Op 3 (mul) uses the signed low 16 bits of each operand. The block passes operands unmodified.
- Arithmetic is 32-bit wrap-around with no overflow flag.
- err and done are never high in the same cycle.

Decomposition:
- Shared package (alu_pkg):
  - Op code constants OP_PASS2=0, OP_PASS1=1, OP_ADD=2, OP_MUL=3, OP_EQ=4, OP_LT=5, OP_NOT2=6, OP_ILLEGAL=7.
  - Instruction field bit positions.
  - FSM state enum.
- Sub-module regfile_2r1w:
  - Two asynchronous read ports and one synchronous write port.
  - Register 0 hardwired to 0; synchronous reset clears all entries.
  - The write mux (host load vs WB) stays in the parent.

Test Plan:
- Load R1=5, R2=0xFFFFFFFD (-3); issue op=2, rd=3, rs1=1, rs2=2, wb_en=1 → done at T+3 with result=2; a later op=1, rs1=3 returns 2.
- Load R1=0x00010002, R2=3; issue op=3 → result=6, showing that bits [31:16] are ignored.
- Issue op=7 → err pulses for one cycle, done never pulses, no register changes, in_ready stays high.
- rd=0 with wb_en=1 and op=6, rs2=0 → result=0xFFFFFFFF, R0 still reads 0. Separately, wb_en=0 → done pulses and rd is unchanged.
- Hold in_valid high with 3 instructions queued → accepted at cycles 0, 4 and 8. Assert ld_we in IDLE together with in_valid → load occurs and the instruction is not accepted until the next cycle.
- Assert rst during EXEC → the next cycle is IDLE with all outputs 0, no done pulse, and the destination register is not written.
